mem_port_arbiter: RTL and testbench

Shares the single-ported data memory between the instruction-fetch stage and the memory-access stage of the pipelined core. Each cycle it grants at most one requester and drives the memory address, write data and write enable. It tags every read so the returned data is routed back, with a valid strobe, to the requester that issued it. Data-side accesses win by default; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data memory between fetch and the memory-access stage.
// Data wins by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_d
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt;
    logic              fetch_pri;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_o;
    logic              push_v;

    // Grant selection and memory drive; grants are suppressed while in reset.
    always_comb begin
        fetch_pri = (starve_cnt == LIMIT);
        f_gnt     = rst_n & f_req & (~d_req | fetch_pri);
        d_gnt     = rst_n & d_req & ~f_gnt;
        stall_f   = f_req & ~f_gnt;
        stall_d   = d_req & ~d_gnt;
        mem_addr  = addr_q;
        mem_wdata = d_wdata;
        mem_we    = d_gnt & d_we;
        if (d_gnt) begin
            mem_addr = d_addr;
        end else if (f_gnt) begin
            mem_addr = f_addr;
        end
        push_v    = (d_gnt & ~d_we) | f_gnt;
    end

    // Starvation counter, held address and read-tag shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            addr_q     <= '0;
            tag_v      <= '0;
            tag_o      <= '0;
        end else begin
            if (f_req & ~f_gnt) begin
                starve_cnt <= fetch_pri ? starve_cnt : starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            addr_q   <= mem_addr;
            tag_v[0] <= push_v;
            tag_o[0] <= f_gnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
        end
    end

    // Returned data is shared; the tag at the tail routes the valid strobe.
    always_comb begin
        d_rvalid = tag_v[RD_LAT-1] & ~tag_o[RD_LAT-1];
        f_rvalid = tag_v[RD_LAT-1] & tag_o[RD_LAT-1];
        d_rdata  = mem_rdata;
        f_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory model.
module tb_mem_port_arbiter;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned LIMIT  = 3;

    logic        clk;
    logic        rst_n;
    logic        d_req, d_we, f_req;
    logic [15:0] d_addr, d_wdata, f_addr;
    logic        d_gnt, d_rvalid, f_gnt, f_rvalid, mem_we, stall_f, stall_d;
    logic [15:0] d_rdata, f_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_d(stall_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          starve = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] refmem [256];
    bit          mon_en = 1'b0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : ({a, ~a} ^ 16'h3C00);
    endfunction

    // Simple pipelined memory: write at the grant edge, data RD_LAT cycles after the address.
    logic [15:0] memarr [256];
    logic [15:0] rpipe [RD_LAT];
    bit          minit;
    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 256; i++) memarr[i] <= init_val(8'(i));
            minit <= 1'b1;
        end else begin
            if (mem_we) memarr[mem_addr[7:0]] <= mem_wdata;
            rpipe[0] <= memarr[mem_addr[7:0]];
            for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Read-response monitor, independent of the stimulus process.
    always @(negedge clk) begin
        if (mon_en) begin
            if (d_rvalid || f_rvalid) begin
                chk("rvalid_exclusive", 32'(d_rvalid & f_rvalid), 32'd0);
                if (q.size() == 0) begin
                    chk("spurious_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
                end else begin
                    chk("rd_owner", 32'(f_rvalid), 32'(q[0].owner));
                    chk("rd_data", 32'(f_rvalid ? f_rdata : d_rdata), 32'(q[0].data));
                    chk("rd_latency", 32'(cyc), 32'(q[0].due));
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("missing_rvalid", 32'(cyc), 32'(q[0].due + 1));
                void'(q.pop_front());
            end
        end
    end

    // One clock cycle: drive inputs, compare against the reference model, advance the model.
    task automatic do_cycle(input logic rst, input logic dr, input logic dwe,
                            input logic [15:0] da, input logic [15:0] dwd,
                            input logic fr, input logic [15:0] fa,
                            output logic gd, output logic gf);
        logic ef, ed;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        f_req = fr; f_addr = fa;
        ef = rst & fr & (~dr | (starve == LIMIT));
        ed = rst & dr & ~ef;
        @(negedge clk);
        chk("f_gnt", 32'(f_gnt), 32'(ef));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("stall_f", 32'(stall_f), 32'(fr & ~ef));
        chk("stall_d", 32'(stall_d), 32'(dr & ~ed));
        chk("mem_we", 32'(mem_we), 32'(ed & dwe));
        if (ef) chk("mem_addr_f", 32'(mem_addr), 32'(fa));
        else if (ed) chk("mem_addr_d", 32'(mem_addr), 32'(da));
        else if (rst) chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
        if (ed & dwe) chk("mem_wdata", 32'(mem_wdata), 32'(dwd));
        if (ef || (ed && !dwe)) begin
            e.owner = ef;
            e.data  = refmem[ef ? fa[7:0] : da[7:0]];
            e.due   = cyc + int'(RD_LAT);
            q.push_back(e);
        end
        if (ed & dwe) refmem[da[7:0]] = dwd;
        if (!rst) begin
            starve = 0;
            last_addr = 16'h0;
            q.delete();
        end else begin
            if (fr && !ef) starve = (starve < int'(LIMIT)) ? starve + 1 : int'(LIMIT);
            else starve = 0;
            if (ef) last_addr = fa;
            else if (ed) last_addr = da;
        end
        gd = ed;
        gf = ef;
    endtask

    task automatic idle(input int n);
        logic gd, gf;
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, gd, gf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gd, gf;
        logic [9:0]  starve_pat;
        logic [3:0]  four_pat;
        logic        pd, pf, pdwe;
        logic [15:0] pda, pdwd, pfa;
        starve_pat = 10'b0010001000;
        four_pat   = 4'b1000;
        for (int i = 0; i < 256; i++) refmem[i] = init_val(8'(i));
        rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        f_req = 1'b0; f_addr = '0;

        // Reset with both requests asserted: no grants, stalls follow requests.
        do_cycle(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0, 1'b1, 16'h0002, gd, gf);
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, gd, gf);
        mon_en = 1'b1;
        idle(1);

        // Single fetch, store, then a load of the stored word.
        do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, gd, gf);
        do_cycle(1'b1, 1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0, 16'h0, gd, gf);
        do_cycle(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 16'h0, gd, gf);
        idle(2);

        // Starvation: both held for 10 cycles gives D,D,D,F,D,D,D,F,D,D.
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 16'(16'h0040 + i), 16'h0, 1'b1, 16'(16'h0080 + i), gd, gf);
            chk("starve_seq", 32'(gf), 32'(starve_pat[i]));
        end
        idle(1);

        // Interleaved data loads and fetches.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) do_cycle(1'b1, 1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 16'h0, gd, gf);
            else do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'(16'h0020 + i), gd, gf);
        end
        idle(1);

        // Fetch drop: two denials, one cycle without fetch, then D,D,D,F.
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 1'b1, 16'h0012, gd, gf);
        do_cycle(1'b1, 1'b1, 1'b0, 16'h0013, 16'h0, 1'b0, 16'h0, gd, gf);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 16'h0014, 16'h0, 1'b1, 16'h0015, gd, gf);
            chk("drop_seq", 32'(gf), 32'(four_pat[i]));
        end
        idle(RD_LAT + 1);

        // Reset mid-flight: the load must never return; counter must restart from 0.
        do_cycle(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0, 1'b0, 16'h0, gd, gf);
        do_cycle(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0, 1'b1, 16'h0023, gd, gf);
        idle(RD_LAT + 2);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 16'h0024, 16'h0, 1'b1, 16'h0025, gd, gf);
            chk("post_reset_seq", 32'(gf), 32'(four_pat[i]));
        end
        idle(1);

        // Random traffic obeying the hold-until-grant handshake.
        pd = 1'b0; pf = 1'b0; pdwe = 1'b0; pda = '0; pdwd = '0; pfa = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pd && $urandom_range(0, 99) < 60) begin
                pd   = 1'b1;
                pdwe = ($urandom_range(0, 2) == 0);
                pda  = {8'($urandom), 8'($urandom_range(0, 15))};
                pdwd = 16'($urandom);
            end
            if (!pf && $urandom_range(0, 99) < 50) begin
                pf  = 1'b1;
                pfa = {8'($urandom), 8'($urandom_range(0, 15))};
            end
            do_cycle(1'b1, pd, pdwe, pda, pdwd, pf, pfa, gd, gf);
            if (gd) pd = 1'b0;
            if (gf) pf = 1'b0;
        end

        idle(RD_LAT + 2);
        chk("drain_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
